// File: rtl/fifo_read_ctrl.sv
// Read-side drain engine: pops words from fifo_async into a small ring buffer
// and presents them on a valid/ready stream, counting delivered words.

module fifo_read_ctrl_chk #(
  parameter int OW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          cap,
  input logic          pop,
  input logic [OW-1:0] occ,
  input logic [OW-1:0] depth
);

  // A capture into a full buffer without a simultaneous pop would overwrite a word
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(cap && (occ == depth) && !pop))
        else $error("fifo_read_ctrl: capture into full buffer");
    end
  end

endmodule

module fifo_read_ctrl #(
  parameter int DW        = 8,
  parameter int BUF_DEPTH = 4,
  parameter int CW        = 16
) (
  input  logic          rd_clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_data,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [CW-1:0] rd_count,
  output logic          busy
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH   = OW'(BUF_DEPTH);
  localparam logic [OW:0]   DEPTH_X = (OW + 1)'(BUF_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          rd_pend_q, rd_pend_d;
  logic [CW-1:0] rd_count_q, rd_count_d;
  logic [DW-1:0] buf_q [BUF_DEPTH];
  logic [DW-1:0] buf_d [BUF_DEPTH];
  logic [OW:0]   fill_s;
  logic          pop_s;

  // In-flight read counts against capacity so the buffer can never overflow
  assign fill_s   = {1'b0, occ_q} + {{OW{1'b0}}, rd_pend_q};
  assign fifo_rd  = (state_q == RUN) && !fifo_empty && (fill_s < DEPTH_X);
  assign m_valid  = (occ_q != {OW{1'b0}});
  assign m_data   = buf_q[rd_ptr_q];
  assign rd_count = rd_count_q;
  assign busy     = (state_q != IDLE) || m_valid || rd_pend_q;
  assign pop_s    = m_valid && m_ready;

  // Next-state logic for FSM, buffer pointers, occupancy and counter
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    rd_pend_d  = fifo_rd;
    rd_count_d = rd_count_q + {{(CW-1){1'b0}}, pop_s};
    case (state_q)
      IDLE:    if (en) state_d = RUN; else state_d = IDLE;
      RUN:     if (!en) state_d = DRAIN; else state_d = RUN;
      DRAIN: begin
        if (en) state_d = RUN;
        else if (!m_valid && !rd_pend_q) state_d = IDLE;
        else state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
    if (rd_pend_q) begin
      buf_d[wr_ptr_q] = fifo_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE; else rd_ptr_d = rd_ptr_q;
    case ({rd_pend_q, pop_s})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset discards buffered and in-flight words
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      occ_q      <= {OW{1'b0}};
      rd_pend_q  <= 1'b0;
      rd_count_q <= {CW{1'b0}};
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rd_pend_q  <= rd_pend_d;
      rd_count_q <= rd_count_d;
      buf_q      <= buf_d;
    end
  end

  fifo_read_ctrl_chk #(.OW(OW)) u_chk (
    .clk   (rd_clk),
    .rst   (rst),
    .cap   (rd_pend_q),
    .pop   (pop_s),
    .occ   (occ_q),
    .depth (DEPTH)
  );

endmodule
